// File: rtl/rsi_engine_if.sv
// rsi_engine_if: price-in / rsi-out handshake bundle for rsi_engine.
// The engine side uses the slave modport; the source/consumer side uses master.
// With RSI_THRESH_EN defined the bundle also carries ob_flag/os_flag.
interface rsi_engine_if #(
   parameter int DW   = 16,
   parameter int FRAC = 0
);
   localparam int OUT_W = 7 + FRAC;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_price;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] rsi;
   logic             warm;
`ifdef RSI_THRESH_EN
   logic             ob_flag;
   logic             os_flag;
`endif

   modport slave (
      input  flush, in_valid, in_price, out_ready,
`ifdef RSI_THRESH_EN
      output ob_flag, os_flag,
`endif
      output in_ready, out_valid, rsi, warm
   );

   modport master (
      output flush, in_valid, in_price, out_ready,
`ifdef RSI_THRESH_EN
      input  ob_flag, os_flag,
`endif
      input  in_ready, out_valid, rsi, warm
   );
endinterface

// File: rtl/rsi_engine.sv
// rsi_engine: PERIOD-length RSI over a streaming price feed.
// MODE 0 keeps sliding-window gain/loss sums backed by a ring of deltas;
// MODE 1 applies Wilder smoothing after a PERIOD-delta seed.
// Each warm sample runs a restoring divider, one quotient bit per cycle.
// Optional macro RSI_THRESH_EN adds registered overbought/oversold flags.
module rsi_engine #(
   parameter int DW     = 16,
   parameter int PERIOD = 14,
   parameter int ACC_W  = DW + 7,
   parameter int MODE   = 0,
   parameter int FRAC   = 0
`ifdef RSI_THRESH_EN
   ,
   parameter int OB_LVL = 70,
   parameter int OS_LVL = 30
`endif
) (
   input logic         clk,
   input logic         rst_n,
   rsi_engine_if.slave bus
);
   localparam int OUT_W = 7 + FRAC;
   localparam int NW    = ACC_W + OUT_W;
   localparam int CW    = $clog2(OUT_W);
   localparam int PW    = $clog2(PERIOD);
   localparam int KW    = $clog2(PERIOD + 1);
   localparam logic [OUT_W-1:0] FULL = OUT_W'(100 << FRAC);
   localparam logic [OUT_W-1:0] HALF = OUT_W'(50 << FRAC);

   typedef enum logic [1:0] {IDLE, UPDATE, DIV, OUT} state_t;

   state_t           state_q, state_d;
   logic             rdy_en_q;
   logic [DW-1:0]    price_q, price_d, prev_q, prev_d;
   logic             have_prev_q, have_prev_d;
   logic [ACC_W-1:0] sg_q, sg_d, sl_q, sl_d;
   logic [KW-1:0]    cnt_q, cnt_d;
   logic             warm_q, warm_d;
   logic [NW-1:0]    rem_q, rem_d, dvs_q, dvs_d;
   logic [OUT_W-1:0] quo_q, quo_d, rsi_q, rsi_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic             zero_q, zero_d;

   logic             accept, upd_en, div_done;
   logic [DW:0]      delta, delta_neg;
   logic [ACC_W-1:0] gain, loss, sg_upd, sl_upd;
   logic [ACC_W:0]   den;

   assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
   assign upd_en   = (state_q == UPDATE) && have_prev_q && !bus.flush;
   assign div_done = (state_q == DIV) && (bit_q == '0) && !bus.flush;

   // Zero-extend both prices so the MSB of the difference is its sign.
   assign delta     = {1'b0, price_q} - {1'b0, prev_q};
   assign delta_neg = -delta;
   assign gain      = delta[DW] ? '0 : ACC_W'(delta[DW-1:0]);
   assign loss      = delta[DW] ? ACC_W'(delta_neg[DW-1:0]) : '0;
   assign den       = {1'b0, sg_upd} + {1'b0, sl_upd};

   generate
      if (MODE == 0) begin : g_window
         logic [DW:0]      ring_q [PERIOD];
         logic [PW-1:0]    ptr_q;
         logic [DW:0]      ev, ev_neg;
         logic [ACC_W-1:0] ev_gain, ev_loss;

         assign ev      = ring_q[ptr_q];
         assign ev_neg  = -ev;
         assign ev_gain = ev[DW] ? '0 : ACC_W'(ev[DW-1:0]);
         assign ev_loss = ev[DW] ? ACC_W'(ev_neg[DW-1:0]) : '0;
         assign sg_upd  = sg_q + gain - (warm_q ? ev_gain : '0);
         assign sl_upd  = sl_q + loss - (warm_q ? ev_loss : '0);

         // Ring storage of the last PERIOD deltas.
         // NOTE: no reset on the ring; a slot is always rewritten after a
         // flush before it is evicted, so stale contents are never read.
         always_ff @(posedge clk) begin
            if (upd_en) ring_q[ptr_q] <= delta;
         end

         // Ring pointer: advances per delta, wraps at PERIOD-1.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         ptr_q <= '0;
            else if (bus.flush) ptr_q <= '0;
            else if (upd_en)    ptr_q <= (ptr_q == PW'(PERIOD - 1)) ? '0 : ptr_q + PW'(1);
         end
      end else begin : g_wilder
         assign sg_upd = warm_q ? (sg_q - sg_q / ACC_W'(PERIOD) + gain) : (sg_q + gain);
         assign sl_upd = warm_q ? (sl_q - sl_q / ACC_W'(PERIOD) + loss) : (sl_q + loss);
      end
   endgenerate

   // Next-state logic: FSM, sums and divider datapath.
   always_comb begin
      // NOTE: every target gets its hold value first so no path infers a latch.
      state_d     = state_q;
      price_d     = price_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      sg_d        = sg_q;
      sl_d        = sl_q;
      cnt_d       = cnt_q;
      warm_d      = warm_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      quo_d       = quo_q;
      bit_d       = bit_q;
      zero_d      = zero_q;
      rsi_d       = rsi_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               price_d = bus.in_price;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            prev_d      = price_q;
            have_prev_d = 1'b1;
            state_d     = IDLE;
            if (have_prev_q) begin
               sg_d = sg_upd;
               sl_d = sl_upd;
               if (!warm_q) cnt_d = cnt_q + KW'(1);
               if (warm_q || cnt_q == KW'(PERIOD - 1)) begin
                  warm_d  = 1'b1;
                  state_d = DIV;
                  rem_d   = NW'(FULL) * NW'(sg_upd);
                  dvs_d   = NW'(den) << (OUT_W - 1);
                  zero_d  = (den == '0);
                  quo_d   = '0;
                  bit_d   = CW'(OUT_W - 1);
               end
            end
         end
         DIV: begin
            if (rem_q >= dvs_q) begin
               rem_d = rem_q - dvs_q;
               quo_d = {quo_q[OUT_W-2:0], 1'b1};
            end else begin
               quo_d = {quo_q[OUT_W-2:0], 1'b0};
            end
            dvs_d = dvs_q >> 1;
            bit_d = bit_q - CW'(1);
            if (bit_q == '0) begin
               state_d = OUT;
               rsi_d   = zero_q ? HALF : quo_d;
            end
         end
         OUT: begin
            if (bus.out_ready) state_d = IDLE;
         end
      endcase
      if (bus.flush) begin
         state_d     = IDLE;
         have_prev_d = 1'b0;
         sg_d        = '0;
         sl_d        = '0;
         cnt_d       = '0;
         warm_d      = 1'b0;
         rsi_d       = rsi_q;
      end
   end

   // State registers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rdy_en_q    <= 1'b0;
         price_q     <= '0;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         sg_q        <= '0;
         sl_q        <= '0;
         cnt_q       <= '0;
         warm_q      <= 1'b0;
         rem_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         bit_q       <= '0;
         zero_q      <= 1'b0;
         rsi_q       <= '0;
      end else begin
         state_q     <= state_d;
         rdy_en_q    <= 1'b1;
         price_q     <= price_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         sg_q        <= sg_d;
         sl_q        <= sl_d;
         cnt_q       <= cnt_d;
         warm_q      <= warm_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         bit_q       <= bit_d;
         zero_q      <= zero_d;
         rsi_q       <= rsi_d;
      end
   end

`ifdef RSI_THRESH_EN
   localparam logic [OUT_W-1:0] OB_TH = OUT_W'(OB_LVL << FRAC);
   localparam logic [OUT_W-1:0] OS_TH = OUT_W'(OS_LVL << FRAC);
   logic ob_q, os_q;

   // Threshold flags, refreshed together with rsi.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ob_q <= 1'b0;
         os_q <= 1'b0;
      end else if (bus.flush) begin
         ob_q <= 1'b0;
         os_q <= 1'b0;
      end else if (div_done) begin
         ob_q <= (rsi_d >= OB_TH);
         os_q <= (rsi_d <= OS_TH);
      end
   end

   assign bus.ob_flag = ob_q;
   assign bus.os_flag = os_q;
`endif

   assign bus.in_ready  = rdy_en_q && (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.rsi       = rsi_q;
   assign bus.warm      = warm_q;
endmodule

// File: tb/tb_rsi_engine.sv
// tb_rsi_engine: scoreboard bench for rsi_engine with PERIOD=4.
// DUT 0: MODE 0, FRAC 0.  DUT 1: MODE 0, FRAC 2.  DUT 2: MODE 1, FRAC 0.
// Stimulus pushes hand-computed rsi values; the monitor pops on each handshake.
module tb_rsi_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]  iv, ordy, fl;
   logic [15:0] ip [3];
   wire  [2:0]  ov, ir, wm;
   wire  [8:0]  rs [3];

   rsi_engine_if #(.DW(16), .FRAC(0)) if_a ();
   rsi_engine_if #(.DW(16), .FRAC(2)) if_b ();
   rsi_engine_if #(.DW(16), .FRAC(0)) if_c ();

   rsi_engine #(.DW(16), .PERIOD(4), .ACC_W(23), .MODE(0), .FRAC(0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   rsi_engine #(.DW(16), .PERIOD(4), .ACC_W(23), .MODE(0), .FRAC(2))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   rsi_engine #(.DW(16), .PERIOD(4), .ACC_W(23), .MODE(1), .FRAC(0))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   assign if_a.in_valid = iv[0];   assign if_b.in_valid = iv[1];   assign if_c.in_valid = iv[2];
   assign if_a.in_price = ip[0];   assign if_b.in_price = ip[1];   assign if_c.in_price = ip[2];
   assign if_a.out_ready = ordy[0]; assign if_b.out_ready = ordy[1]; assign if_c.out_ready = ordy[2];
   assign if_a.flush = fl[0];      assign if_b.flush = fl[1];      assign if_c.flush = fl[2];
   assign ov[0] = if_a.out_valid;  assign ov[1] = if_b.out_valid;  assign ov[2] = if_c.out_valid;
   assign ir[0] = if_a.in_ready;   assign ir[1] = if_b.in_ready;   assign ir[2] = if_c.in_ready;
   assign wm[0] = if_a.warm;       assign wm[1] = if_b.warm;       assign wm[2] = if_c.warm;
   assign rs[0] = 9'(if_a.rsi);    assign rs[1] = 9'(if_b.rsi);    assign rs[2] = 9'(if_c.rsi);
`ifdef RSI_THRESH_EN
   wire [2:0] obf, osf;
   assign obf[0] = if_a.ob_flag; assign obf[1] = if_b.ob_flag; assign obf[2] = if_c.ob_flag;
   assign osf[0] = if_a.os_flag; assign osf[1] = if_b.os_flag; assign osf[2] = if_c.os_flag;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int exp0[$], exp1[$], exp2[$];
   int hs[3] = '{0, 0, 0};
   int last_hs[3] = '{0, 0, 0};
   int prev_hs[3] = '{0, 0, 0};
   int last_k = 0;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic unexpected(int i, int v);
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out dut=%0d: got rsi %0d, want no output", i, v);
   endtask

   task automatic on_handshake(int i, int want);
      hs[i]++;
      prev_hs[i] = last_hs[i];
      last_hs[i] = cyc;
      check($sformatf("rsi_dut%0d", i), int'(rs[i]), want);
      check($sformatf("warm_at_out_dut%0d", i), int'(wm[i]), 1);
`ifdef RSI_THRESH_EN
      check($sformatf("ob_flag_dut%0d", i), int'(obf[i]), int'(want >= (i == 1 ? 280 : 70)));
      check($sformatf("os_flag_dut%0d", i), int'(osf[i]), int'(want <= (i == 1 ? 120 : 30)));
`endif
   endtask

   // Monitor: compare every accepted result against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ov[0] && ordy[0]) begin
            if (exp0.size() == 0) unexpected(0, int'(rs[0]));
            else on_handshake(0, exp0.pop_front());
         end
         if (ov[1] && ordy[1]) begin
            if (exp1.size() == 0) unexpected(1, int'(rs[1]));
            else on_handshake(1, exp1.pop_front());
         end
         if (ov[2] && ordy[2]) begin
            if (exp2.size() == 0) unexpected(2, int'(rs[2]));
            else on_handshake(2, exp2.pop_front());
         end
      end
   end

   task automatic send(int i, int price);
      int n = 0;
      @(posedge clk); #1;
      iv[i] = 1'b1;
      ip[i] = 16'(price);
      @(negedge clk);
      while (!ir[i] && n < 300) begin @(negedge clk); n++; end
      if (!ir[i]) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout dut=%0d price=%0d: in_ready stayed 0", i, price);
      end
      last_k = cyc;
      @(posedge clk); #1;
      iv[i] = 1'b0;
   endtask

   task automatic wait_idle(int i);
      int n = 0;
      @(negedge clk);
      while (!ir[i] && n < 300) begin @(negedge clk); n++; end
      if (!ir[i]) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout dut=%0d: in_ready stayed 0", i);
      end
   endtask

   task automatic wait_out(int i, output int t);
      int n = 0;
      @(negedge clk);
      while (!ov[i] && n < 300) begin @(negedge clk); n++; end
      if (!ov[i]) begin
         n_checks++; n_fail++;
         $display("FAIL out_timeout dut=%0d: out_valid stayed 0", i);
      end
      t = cyc;
   endtask

   task automatic do_flush(int i);
      @(posedge clk); #1;
      fl[i] = 1'b1;
      @(posedge clk); #1;
      fl[i] = 1'b0;
   endtask

   task automatic send_list(int i, int a, int b, int c, int d, int e);
      send(i, a); send(i, b); send(i, c); send(i, d); send(i, e);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int hs_before;
      iv = '0; ordy = 3'b111; fl = '0;
      for (int i = 0; i < 3; i++) ip[i] = '0;

      // Reset values.
      #12;
      check("reset_in_ready", int'(ir[0]), 0);
      check("reset_out_valid", int'(ov[0]), 0);
      check("reset_rsi", int'(rs[0]), 0);
      check("reset_warm", int'(wm[0]), 0);
      #10 rst_n = 1'b1;
      #1 check("in_ready_before_first_clk", int'(ir[0]), 0);
      @(negedge clk);
      check("in_ready_after_first_clk", int'(ir[0]), 1);

      // Rising prices: first result only after the 5th sample.
      send(0, 100); send(0, 101); send(0, 102); send(0, 103);
      wait_idle(0);
      check("warm_before_period", int'(wm[0]), 0);
      exp0.push_back(100);
      send(0, 104);
      wait_out(0, t);
      check("latency_k_to_out_valid", t - last_k, 9);
      check("warm_after_period", int'(wm[0]), 1);
      wait_idle(0);
      exp0.push_back(60); send(0, 102);
      exp0.push_back(40); send(0, 101);
      wait_idle(0);

      // Flat prices give the zero-denominator midpoint; truncating quotient.
      do_flush(0);
      exp0.push_back(50);
      send_list(0, 50, 50, 50, 50, 50);
      wait_idle(0);
      do_flush(0);
      exp0.push_back(33);
      send_list(0, 10, 10, 11, 9, 9);
      wait_idle(0);

      // Backpressure: result held 20 cycles while a new price waits.
      do_flush(0);
      send(0, 100); send(0, 101); send(0, 102); send(0, 103);
      ordy[0] = 1'b0;
      exp0.push_back(100);
      send(0, 104);
      wait_out(0, t);
      iv[0] = 1'b1;
      ip[0] = 16'd0;
      for (int n = 0; n < 20; n++) begin
         check("hold_out_valid", int'(ov[0]), 1);
         check("hold_rsi", int'(rs[0]), 100);
         check("hold_in_ready", int'(ir[0]), 0);
         @(negedge clk);
      end
      hs_before = hs[0];
      exp0.push_back(2);
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_in_ready", int'(ir[0]), 1);
      check("release_one_handshake", hs[0], hs_before + 1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      wait_idle(0);

      // Flush during DIV: no result, warm clears, rsi keeps last value.
      do_flush(0);
      send(0, 100); send(0, 101); send(0, 102); send(0, 103); send(0, 104);
      @(posedge clk);
      do_flush(0);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         check("flush_no_out_valid", int'(ov[0]), 0);
      end
      check("flush_warm", int'(wm[0]), 0);
      check("flush_rsi_kept", int'(rs[0]), 2);
      exp0.push_back(66);
      send_list(0, 50, 52, 51, 53, 52);
      wait_idle(0);

      // FRAC=2, back-to-back throughput.
      exp1.push_back(240); exp1.push_back(240); exp1.push_back(240);
      send(1, 100); send(1, 101); send(1, 102); send(1, 103);
      send(1, 101); send(1, 102); send(1, 103);
      wait_idle(1);
      check("throughput_frac2", last_hs[1] - prev_hs[1], 12);

      // Wilder smoothing.
      exp2.push_back(50);
      send_list(2, 100, 104, 100, 104, 100);
      exp2.push_back(70);
      send(2, 108);
      wait_idle(2);

      // Async reset while a result is held in OUT.
      ordy[2] = 1'b0;
      send(2, 100);
      wait_out(2, t);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", int'(ov[2]), 0);
      check("async_rst_rsi", int'(rs[2]), 0);
      check("async_rst_warm", int'(wm[2]), 0);
      check("async_rst_in_ready", int'(ir[2]), 0);
      check("async_rst_rsi_dut0", int'(rs[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rerelease_in_ready_low", int'(ir[2]), 0);
      @(negedge clk);
      check("rerelease_in_ready_high", int'(ir[2]), 1);
      ordy[2] = 1'b1;
      repeat (3) @(negedge clk);

      check("queue_empty_dut0", exp0.size(), 0);
      check("queue_empty_dut1", exp1.size(), 0);
      check("queue_empty_dut2", exp2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rsi_engine.md
Name: rsi_engine

Overview:
- Parametrised successor to the incremental RSI block: true PERIOD-length RSI over a streaming price feed.
- Sits between the price FIFO/strobe source and the indicator aggregation FSM.
- Two modes: sliding-window (Cutler) sums, or Wilder smoothing.
- Ready/valid handshakes on both sides; a multi-cycle serial divider replaces the single-cycle divide.

Parameters:
- DW, 16: price width (unsigned).
- PERIOD, 14: RSI period in deltas, legal range 2..64.
- ACC_W, DW+7: gain/loss accumulator width; must hold PERIOD*(2^DW-1).
- MODE, 0: 0 = sliding-window sums over the last PERIOD deltas; 1 = Wilder smoothing.
- FRAC, 0: output fraction bits; full scale 100<<FRAC.
- OUT_W, 7+FRAC: rsi width (derived, do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous restart of warm-up; clears all history.
- in_valid  in  1  price available.
- in_ready  out  1  engine can accept a price.
- in_price  in  DW  unsigned price.
- out_valid  out  1  rsi valid; held until accepted.
- out_ready  in  1  consumer accepts rsi.
- rsi  out  OUT_W  RSI scaled 0..100<<FRAC.
- warm  out  1  high once PERIOD deltas have been collected.

Behaviour:
- Reset (rst_n low, async):
  - in_ready=0, out_valid=0, rsi=0, warm=0.
  - Sums, delta count, ring pointer and first-sample flag cleared; state=IDLE.
  - in_ready rises on the first clk after rst_n deasserts.
- FSM:
  - IDLE: in_ready=1. An accepted sample (in_valid & in_ready) goes to UPDATE.
  - UPDATE: one cycle. Applies the delta. If warm, go to DIV; otherwise back to IDLE.
  - DIV: OUT_W cycles, restoring division, one quotient bit per cycle. Then OUT.
  - OUT: out_valid=1 and rsi held stable until out_ready, then IDLE. out_ready is ignored when out_valid=0.
- Latency: sample accepted at edge k gives out_valid high after edge k+OUT_W+2. in_ready is low from edge k+1 until the return to IDLE.
- Back-to-back throughput: one result per OUT_W+3 cycles when out_ready is tied high.
- First sample after reset/flush: only latches prev_price. No delta, no output.
- Deltas:
  - d = price - prev_price, computed as a (DW+1)-bit signed value.
  - gain = d>0 ? d : 0; loss = d<0 ? -d : 0.
  - Equal prices are a zero delta and still count as a sample.
- MODE 0:
  - Ring buffer of PERIOD signed deltas; pointer wraps from PERIOD-1 to 0.
  - Before warm: add gain/loss to the sums.
  - When warm: also subtract the evicted entry's gain/loss from the sums in the same UPDATE cycle.
- MODE 1:
  - Seed: sums accumulate the first PERIOD deltas.
  - After seed: S = S - floor(S/PERIOD) + gain (and likewise for loss).
  - No ring buffer is instantiated.
- warm asserts in the UPDATE cycle of the PERIOD-th delta; that delta produces the first output.
- RSI:
  - Numerator = (100<<FRAC)*Sg, (ACC_W+OUT_W) bits; denominator = Sg+Sl.
  - Quotient truncates.
  - Sg+Sl == 0 gives rsi = 50<<FRAC; the divider is skipped but DIV timing is kept.
- flush:
  - Any state returns to IDLE next cycle; history cleared; warm=0.
  - Aborts any DIV/OUT with no out_valid pulse; rsi keeps its last value.
  - flush with in_valid in the same cycle: the sample is dropped.
- in_valid while in_ready=0: not consumed; the source must hold.
- Accumulators never overflow given the ACC_W rule. No saturation logic.

Optional Feature:
- Macro RSI_THRESH_EN.
- Defined:
  - Adds output ports ob_flag and os_flag, 1 bit each, and parameters OB_LVL=70 and OS_LVL=30 (unscaled).
  - ob_flag = rsi >= OB_LVL<<FRAC; os_flag = rsi <= OS_LVL<<FRAC.
  - Both registered, updated in the same cycle as rsi, cleared by reset and flush.
- Undefined: ports and comparators absent; behaviour otherwise identical.

Test Plan:
- MODE0 PERIOD=4 FRAC=0:
  - Prices 100,101,102,103,104: no out_valid for the first 4 samples.
  - 5th sample gives rsi=100, warm=1, out_valid at k+9.
- Continue with 102: window deltas +1,+1,+1,-2, so gain 3, loss 2, rsi=60. Then 101: window +1,+1,-2,-1, rsi=40.
- Five prices of 50: total zero, rsi=50. With FRAC=2, prices 100,101,102,103,101 give rsi=240. Prices 10,10,11,9,9 give gain 1, loss 2, rsi=33 (truncation).
- MODE1 PERIOD=4:
  - Prices 100,104,100,104,100: rsi=50.
  - Then 108: Sg=8-2+8=14, Sl=8-2=6, rsi=70.
- Backpressure: hold out_ready=0 for 20 cycles. Required: out_valid and rsi stable, in_ready=0, held in_price not consumed. Release gives one handshake, then in_ready=1.
- Abort cases:
  - flush asserted during DIV: no out_valid, warm=0, next 5 samples rebuild the first result.
  - rst_n pulsed low mid-OUT: all outputs 0 immediately (async).
